// File: rtl/elevador_n_andares.sv
// Purpose : N-floor elevator controller with latched calls, SCAN scheduling, timed travel,
//           a door timer and a saturating occupant counter.
// Latency : a call sampled at edge k starts the motor or opens the door after edge k+1.
//           Each floor takes TRAVEL_CYCLES edges to cross.
// Backpressure: none. Calls are latched in 'pending' until served, so nothing is lost.
//           Enter/exit pulses outside DOOR_OPEN, enter at capacity and exit at zero are dropped.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   req[N_FLOORS]               call buttons, one bit per floor
//   person_enter/person_exit    one occupant per high cycle, counted only while the door is open
//   emergency_stop              present only when EMERGENCY_STOP_EN is defined
//   motor_up/motor_down         car moving up/down (state decode, mutually exclusive with door_open)
//   door_open                   door open
//   andar_atual                 current floor
//   andar_requisitado           floor the car is heading to (equals andar_atual when not moving)
//   num_people, full            occupancy and capacity flag
//   pending                     outstanding latched calls
//
// Optional feature macro: EMERGENCY_STOP_EN (adds the emergency_stop input that freezes the FSM).
module elevador_n_andares #(
    parameter int N_FLOORS      = 5,
    parameter int FLOOR_W       = 3,
    parameter int MAX_PEOPLE    = 8,
    parameter int PEOPLE_W      = 4,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] req,
    input  logic                person_enter,
    input  logic                person_exit,
`ifdef EMERGENCY_STOP_EN
    input  logic                emergency_stop,
`endif
    output logic                motor_up,
    output logic                motor_down,
    output logic                door_open,
    output logic [FLOOR_W-1:0]  andar_atual,
    output logic [FLOOR_W-1:0]  andar_requisitado,
    output logic [PEOPLE_W-1:0] num_people,
    output logic [N_FLOORS-1:0] pending,
    output logic                full
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] MOVE_UP   = 2'd1;
    localparam logic [1:0] MOVE_DOWN = 2'd2;
    localparam logic [1:0] DOOR_OPEN = 2'd3;

    localparam int TRAV_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DOOR_W = $clog2(DOOR_CYCLES + 1);

    localparam logic [TRAV_W-1:0]   TRAV_LAST = TRAV_W'(TRAVEL_CYCLES - 1);
    localparam logic [DOOR_W-1:0]   DOOR_LOAD = DOOR_W'(DOOR_CYCLES);
    localparam logic [FLOOR_W-1:0]  TOP_FLOOR = FLOOR_W'(N_FLOORS - 1);
    localparam logic [PEOPLE_W-1:0] MAX_P     = PEOPLE_W'(MAX_PEOPLE);

    logic [1:0]          state, state_nxt;
    logic                dir, dir_nxt;          // 1 = up
    logic [TRAV_W-1:0]   trav_cnt, trav_nxt;
    logic [DOOR_W-1:0]   door_cnt, door_nxt;
    logic [FLOOR_W-1:0]  floor_nxt;
    logic [N_FLOORS-1:0] clear_mask;
    logic                halt;

    logic                pend_here, pend_above, pend_below, req_here;
    logic [FLOOR_W-1:0]  near_up, near_dn;

`ifdef EMERGENCY_STOP_EN
    assign halt = emergency_stop;
`else
    assign halt = 1'b0;
`endif

    // Pending-call scan relative to the current floor. The up loop runs top-down and the
    // down loop bottom-up so the last hit is the nearest call in each direction.
    always_comb begin
        pend_here  = 1'b0;
        req_here   = 1'b0;
        pend_above = 1'b0;
        pend_below = 1'b0;
        near_up    = andar_atual;
        near_dn    = andar_atual;
        for (int i = N_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (FLOOR_W'(i) > andar_atual)) begin
                pend_above = 1'b1;
                near_up    = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pending[i] && (FLOOR_W'(i) < andar_atual)) begin
                pend_below = 1'b1;
                near_dn    = FLOOR_W'(i);
            end
            if (FLOOR_W'(i) == andar_atual) begin
                pend_here = pending[i];
                req_here  = req[i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        trav_nxt  = trav_cnt;
        door_nxt  = door_cnt;
        floor_nxt = andar_atual;
        if (!halt) begin
            case (state)
                IDLE: begin
                    if (pend_here) begin
                        state_nxt = DOOR_OPEN;
                        door_nxt  = DOOR_LOAD;
                    end else if (pend_above && (dir || !pend_below)) begin
                        state_nxt = MOVE_UP;
                        dir_nxt   = 1'b1;
                        trav_nxt  = '0;
                    end else if (pend_below) begin
                        state_nxt = MOVE_DOWN;
                        dir_nxt   = 1'b0;
                        trav_nxt  = '0;
                    end
                end
                MOVE_UP: begin
                    if (trav_cnt == TRAV_LAST) begin
                        trav_nxt = '0;
                        if (!pend_above || (andar_atual == TOP_FLOOR)) begin
                            // Nothing left ahead: stop here rather than overshoot.
                            state_nxt = IDLE;
                        end else begin
                            floor_nxt = andar_atual + FLOOR_W'(1);
                            if (near_up == floor_nxt) begin
                                state_nxt = DOOR_OPEN;
                                door_nxt  = DOOR_LOAD;
                            end
                        end
                    end else begin
                        trav_nxt = trav_cnt + TRAV_W'(1);
                    end
                end
                MOVE_DOWN: begin
                    if (trav_cnt == TRAV_LAST) begin
                        trav_nxt = '0;
                        if (!pend_below || (andar_atual == '0)) begin
                            state_nxt = IDLE;
                        end else begin
                            floor_nxt = andar_atual - FLOOR_W'(1);
                            if (near_dn == floor_nxt) begin
                                state_nxt = DOOR_OPEN;
                                door_nxt  = DOOR_LOAD;
                            end
                        end
                    end else begin
                        trav_nxt = trav_cnt + TRAV_W'(1);
                    end
                end
                default: begin // DOOR_OPEN
                    // A call for this floor while open just keeps the door open longer.
                    if (person_enter || person_exit || req_here) begin
                        door_nxt = DOOR_LOAD;
                    end else if (door_cnt <= DOOR_W'(1)) begin
                        state_nxt = IDLE;
                        door_nxt  = '0;
                    end else begin
                        door_nxt = door_cnt - DOOR_W'(1);
                    end
                end
            endcase
        end
    end

    // A floor's call is cleared whenever the next state is DOOR_OPEN at that floor; this covers
    // both arrival and calls absorbed while the door is already open.
    always_comb begin
        clear_mask = '0;
        if (state_nxt == DOOR_OPEN) begin
            for (int i = 0; i < N_FLOORS; i++) begin
                if (FLOOR_W'(i) == floor_nxt) begin
                    clear_mask[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            dir         <= 1'b1;
            trav_cnt    <= '0;
            door_cnt    <= '0;
            andar_atual <= '0;
            pending     <= '0;
            num_people  <= '0;
        end else begin
            state       <= state_nxt;
            dir         <= dir_nxt;
            trav_cnt    <= trav_nxt;
            door_cnt    <= door_nxt;
            andar_atual <= floor_nxt;
            pending     <= (pending | req) & ~clear_mask;
            if ((state == DOOR_OPEN) && !halt) begin
                if (person_enter && !person_exit && !full) begin
                    num_people <= num_people + PEOPLE_W'(1);
                end else if (person_exit && !person_enter && (num_people != '0)) begin
                    num_people <= num_people - PEOPLE_W'(1);
                end
            end
        end
    end

    assign motor_up   = (state == MOVE_UP)   && !halt;
    assign motor_down = (state == MOVE_DOWN) && !halt;
    assign door_open  = (state == DOOR_OPEN) && !halt;
    assign full       = (num_people == MAX_P);

    always_comb begin
        case (state)
            MOVE_UP:   andar_requisitado = near_up;
            MOVE_DOWN: andar_requisitado = near_dn;
            default:   andar_requisitado = andar_atual;
        endcase
    end

endmodule
